// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO that drains itself, popping one entry every
//               READ_DIV clocks. The optional sticky overflow_flag output is
//               enabled by defining FIFO_OVERFLOW_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ps/1ps
`default_nettype none

module sync_fifo #(
    parameter int SIZE     = 8,
    parameter int DEPTH    = 4,
    parameter int READ_DIV = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [SIZE-1:0] data_in,
    input  logic            valid_write,
    output logic [SIZE-1:0] data_out,
    output logic            full_flag,
    output logic            empty_flag,
    output logic            almost_full_flag,
    output logic            almost_empty_flag
`ifdef FIFO_OVERFLOW_FLAG_EN
    ,
    output logic            overflow_flag
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(READ_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SIZE-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [DIV_W-1:0] div_cnt;

    logic tick;
    logic push;
    logic pop;

    assign full_flag         = (count == CNT_FULL);
    assign empty_flag        = (count == '0);
    assign almost_full_flag  = (count >= CNT_AFULL);
    assign almost_empty_flag = (count <= CNT_ONE);

    // Full is judged on the pre-edge count, so a pop in the same cycle never
    // makes room for a push.
    assign tick = (div_cnt == DIV_LAST);
    assign push = valid_write & ~full_flag;
    assign pop  = tick & ~empty_flag;

    // Storage carries no reset; stale words are unreachable once count is 0.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            div_cnt  <= '0;
            data_out <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_OVERFLOW_FLAG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_flag <= 1'b0;
        end else if (valid_write && full_flag) begin
            overflow_flag <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ps/1ps
`default_nettype none

module tb_sync_fifo;

    localparam int SIZE     = 8;
    localparam int DEPTH    = 4;
    localparam int READ_DIV = 5;

    logic            clock;
    logic            reset_n;
    logic [SIZE-1:0] data_in;
    logic            valid_write;
    logic [SIZE-1:0] data_out;
    logic            full_flag;
    logic            empty_flag;
    logic            almost_full_flag;
    logic            almost_empty_flag;
`ifdef FIFO_OVERFLOW_FLAG_EN
    logic            overflow_flag;
`endif

    sync_fifo #(
        .SIZE     (SIZE),
        .DEPTH    (DEPTH),
        .READ_DIV (READ_DIV)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .data_in           (data_in),
        .valid_write       (valid_write),
        .data_out          (data_out),
        .full_flag         (full_flag),
        .empty_flag        (empty_flag),
        .almost_full_flag  (almost_full_flag),
        .almost_empty_flag (almost_empty_flag)
`ifdef FIFO_OVERFLOW_FLAG_EN
        ,
        .overflow_flag     (overflow_flag)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a queue of accepted words plus the number of clock
    // edges seen since reset release (pops fall on every READ_DIV-th edge).
    logic [SIZE-1:0] model_q [$];
    logic [SIZE-1:0] exp_out;
    logic            exp_ovf;
    int              edge_n;
    bit              saw_full;
    int              total;
    int              bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("data_out",     {24'd0, data_out},  {24'd0, exp_out});
        chk("full",         {31'd0, full_flag},  {31'd0, model_q.size() == DEPTH});
        chk("empty",        {31'd0, empty_flag}, {31'd0, model_q.size() == 0});
        chk("almost_full",  {31'd0, almost_full_flag},  {31'd0, model_q.size() >= DEPTH - 1});
        chk("almost_empty", {31'd0, almost_empty_flag}, {31'd0, model_q.size() <= 1});
`ifdef FIFO_OVERFLOW_FLAG_EN
        chk("overflow",     {31'd0, overflow_flag}, {31'd0, exp_ovf});
`endif
        if (full_flag === 1'b1) saw_full = 1'b1;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_out = '0;
        exp_ovf = 1'b0;
        edge_n  = 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic step(input bit vw, input logic [31:0] val);
        bit tick;
        bit is_full;
        bit pop;
        valid_write = vw;
        data_in     = val[SIZE-1:0];
        @(posedge clock);
        tick    = (edge_n % READ_DIV) == (READ_DIV - 1);
        is_full = (model_q.size() == DEPTH);
        pop     = tick && (model_q.size() != 0);
        if (vw && is_full) exp_ovf = 1'b1;
        if (pop) exp_out = model_q.pop_front();
        if (vw && !is_full) model_q.push_back(val[SIZE-1:0]);
        edge_n++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    int burst [10] = '{21, 503, 90, 10, 20, 820, 30, 1, 55, 23};

    initial begin
        total = 0;
        bad   = 0;
        saw_full    = 1'b0;
        reset_n     = 1'b1;
        valid_write = 1'b0;
        data_in     = '0;
        model_reset();

        // Power-on reset
        #10 reset_n = 1'b0;
        #2;
        check_all();
        #58 reset_n = 1'b1;

        // Single write, then let it drain
        step(1'b1, 32'd21);
        chk("single_not_empty", {31'd0, empty_flag}, 32'd0);
        idle(8);
        chk("single_read", {24'd0, data_out}, 32'd21);

        // Burst with truncation and dropped writes while full
        foreach (burst[i]) step(1'b1, burst[i]);
        chk("burst_saw_full", {31'd0, saw_full}, 32'd1);

        // Drain
        idle(25);
        chk("drain_empty", {31'd0, empty_flag}, 32'd1);

        // Reset with entries stored, then a fresh word round-trips
        step(1'b1, 32'd7);
        step(1'b1, 32'd8);
        step(1'b1, 32'd9);
        mid_reset();
        step(1'b1, 32'd28);
        idle(6);
        chk("post_reset_read", {24'd0, data_out}, 32'd28);

        // Randomized traffic at varying write densities, occasional resets
        for (int blk = 0; blk < 8; blk++) begin
            int rate;
            rate = $urandom_range(10, 95);
            for (int i = 0; i < 50; i++) begin
                step($urandom_range(0, 99) < rate, $urandom);
            end
            if (blk == 4) mid_reset();
        end
        idle(30);
        chk("final_empty", {31'd0, empty_flag}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
